// File: rtl/ahb_reset_sequencer_pkg.sv
// Shared types and default parameters for the staged AHB reset sequencer.
// The sequencer walks the bus domains out of reset one at a time, in index order.
package ahb_reset_pkg;

   typedef enum logic [1:0] {
      ST_HOLD = 2'd0,
      ST_WAIT = 2'd1,
      ST_GAP  = 2'd2,
      ST_DONE = 2'd3
   } seq_state_e;

   localparam int DEF_NUM_DOMAINS    = 4;
   localparam int DEF_HOLD_CYCLES    = 16;
   localparam int DEF_GAP_CYCLES     = 8;
   localparam int DEF_TIMEOUT_CYCLES = 256;

   // The shared counter must be wide enough for the longest of the three intervals.
   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = a;
      if (b > m) begin
         m = b;
      end else begin
         m = m;
      end
      if (c > m) begin
         m = c;
      end else begin
         m = m;
      end
      return m;
   endfunction

endpackage

// File: rtl/ahb_reset_sequencer_if.sv
// Reset-control bundle between the sequencer (slave side) and the bus
// domains it releases (master side).
interface ahb_reset_sequencer_if #(
   parameter int NUM_DOMAINS = 4
) ();

   logic                   SoftRstReq;
   logic [NUM_DOMAINS-1:0] DomReady;
   logic [NUM_DOMAINS-1:0] HRESETn;
   logic                   SeqDone;
   logic                   TimeoutErr;

   modport slave (
      input  SoftRstReq,
      input  DomReady,
      output HRESETn,
      output SeqDone,
      output TimeoutErr
   );

   modport master (
      output SoftRstReq,
      output DomReady,
      input  HRESETn,
      input  SeqDone,
      input  TimeoutErr
   );

endinterface

// File: rtl/ahb_reset_sequencer_por_sync.sv
// Power-on reset synchroniser: asserts immediately with POReset, releases
// two HCLK edges after POReset falls.
module por_sync (
   input  logic HCLK,
   input  logic POReset,
   output logic sync_rst
);

   logic [1:0] sync_r;

   // Two-stage shift register, preset to 1 so the release is metastability-filtered.
   always_ff @(posedge HCLK or posedge POReset) begin
      if (POReset) begin
         sync_r <= 2'b11;
      end else begin
         sync_r <= {sync_r[0], 1'b0};
      end
   end

   assign sync_rst = sync_r[1];

endmodule

// File: rtl/ahb_reset_sequencer.sv
// Staged reset release: holds every domain in reset, then releases them one by
// one, each release waiting for that domain's ready or a timeout.
module ahb_reset_sequencer
   import ahb_reset_pkg::*;
#(
   parameter int NUM_DOMAINS    = DEF_NUM_DOMAINS,
   parameter int HOLD_CYCLES    = DEF_HOLD_CYCLES,
   parameter int GAP_CYCLES     = DEF_GAP_CYCLES,
   parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
   input  logic                 HCLK,
   input  logic                 POReset,
   ahb_reset_sequencer_if.slave bus
);

   localparam int CNT_MAX = max3(HOLD_CYCLES, GAP_CYCLES, TIMEOUT_CYCLES);
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam int IDX_W   = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;

   localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
   localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [IDX_W-1:0] IDX_ZERO  = IDX_W'(0);
   localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1);
   localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DOMAINS - 1);

   logic                   sync_rst_s;
   seq_state_e             state_r, state_nxt_s;
   logic [CNT_W-1:0]       cnt_r, cnt_nxt_s;
   logic [IDX_W-1:0]       idx_r, idx_nxt_s, idx_inc_s;
   logic [NUM_DOMAINS-1:0] hresetn_r, hresetn_nxt_s, release_mask_s;
   logic                   seq_done_r, seq_done_nxt_s;
   logic                   timeout_err_r, timeout_err_nxt_s;
   logic                   dom_ready_s;
   logic                   soft_restart_s;

   por_sync u_por_sync (
      .HCLK     (HCLK),
      .POReset  (POReset),
      .sync_rst (sync_rst_s)
   );

   assign idx_inc_s      = idx_r + IDX_ONE;
   assign soft_restart_s = bus.SoftRstReq && (state_r != ST_HOLD);

   // Index decode: the ready bit of the awaited domain and the next domain's release bit.
   always_comb begin
      dom_ready_s    = 1'b0;
      release_mask_s = {NUM_DOMAINS{1'b0}};
      for (int i = 0; i < NUM_DOMAINS; i++) begin
         dom_ready_s       = dom_ready_s | (bus.DomReady[i] & (IDX_W'(i) == idx_r));
         release_mask_s[i] = (IDX_W'(i) == idx_inc_s);
      end
   end

   // Sequencer next-state logic; soft reset outranks ready, ready outranks timeout.
   always_comb begin
      state_nxt_s       = state_r;
      cnt_nxt_s         = cnt_r;
      idx_nxt_s         = idx_r;
      hresetn_nxt_s     = hresetn_r;
      seq_done_nxt_s    = seq_done_r;
      timeout_err_nxt_s = timeout_err_r;

      if (soft_restart_s) begin
         state_nxt_s       = ST_HOLD;
         cnt_nxt_s         = CNT_ZERO;
         idx_nxt_s         = IDX_ZERO;
         hresetn_nxt_s     = {NUM_DOMAINS{1'b0}};
         seq_done_nxt_s    = 1'b0;
         timeout_err_nxt_s = 1'b0;
      end else begin
         case (state_r)
            ST_HOLD: begin
               hresetn_nxt_s  = {NUM_DOMAINS{1'b0}};
               seq_done_nxt_s = 1'b0;
               idx_nxt_s      = IDX_ZERO;
               // A held soft request pins the counter, stretching the hold.
               if (sync_rst_s || bus.SoftRstReq) begin
                  cnt_nxt_s = CNT_ZERO;
               end else if (cnt_r == HOLD_LAST) begin
                  hresetn_nxt_s[0] = 1'b1;
                  cnt_nxt_s        = CNT_ZERO;
                  state_nxt_s      = ST_WAIT;
               end else begin
                  cnt_nxt_s = cnt_r + CNT_ONE;
               end
            end

            ST_WAIT: begin
               if (dom_ready_s || (cnt_r == TO_LAST)) begin
                  timeout_err_nxt_s = timeout_err_r | ~dom_ready_s;
                  cnt_nxt_s         = CNT_ZERO;
                  if (idx_r == IDX_LAST) begin
                     state_nxt_s    = ST_DONE;
                     seq_done_nxt_s = 1'b1;
                  end else begin
                     state_nxt_s = ST_GAP;
                  end
               end else begin
                  cnt_nxt_s = cnt_r + CNT_ONE;
               end
            end

            ST_GAP: begin
               if (cnt_r == GAP_LAST) begin
                  idx_nxt_s     = idx_inc_s;
                  hresetn_nxt_s = hresetn_r | release_mask_s;
                  cnt_nxt_s     = CNT_ZERO;
                  state_nxt_s   = ST_WAIT;
               end else begin
                  cnt_nxt_s = cnt_r + CNT_ONE;
               end
            end

            ST_DONE: begin
               seq_done_nxt_s = 1'b1;
            end

            default: begin
               state_nxt_s       = ST_HOLD;
               cnt_nxt_s         = CNT_ZERO;
               idx_nxt_s         = IDX_ZERO;
               hresetn_nxt_s     = {NUM_DOMAINS{1'b0}};
               seq_done_nxt_s    = 1'b0;
               timeout_err_nxt_s = 1'b0;
            end
         endcase
      end
   end

   // State, counter, index and output registers; POReset clears them without a clock.
   always_ff @(posedge HCLK or posedge POReset) begin
      if (POReset) begin
         state_r       <= ST_HOLD;
         cnt_r         <= CNT_ZERO;
         idx_r         <= IDX_ZERO;
         hresetn_r     <= {NUM_DOMAINS{1'b0}};
         seq_done_r    <= 1'b0;
         timeout_err_r <= 1'b0;
      end else begin
         state_r       <= state_nxt_s;
         cnt_r         <= cnt_nxt_s;
         idx_r         <= idx_nxt_s;
         hresetn_r     <= hresetn_nxt_s;
         seq_done_r    <= seq_done_nxt_s;
         timeout_err_r <= timeout_err_nxt_s;
      end
   end

   assign bus.HRESETn    = hresetn_r;
   assign bus.SeqDone    = seq_done_r;
   assign bus.TimeoutErr = timeout_err_r;

endmodule

// File: tb/tb_ahb_reset_sequencer.sv
// Directed bench for ahb_reset_sequencer with 3 domains, HOLD=4, GAP=2, TIMEOUT=8.
module tb_ahb_reset_sequencer;

   logic HCLK;
   logic POReset;
   int   tests;
   int   fails;

   ahb_reset_sequencer_if #(.NUM_DOMAINS(3)) bus ();

   ahb_reset_sequencer #(
      .NUM_DOMAINS    (3),
      .HOLD_CYCLES    (4),
      .GAP_CYCLES     (2),
      .TIMEOUT_CYCLES (8)
   ) dut (
      .HCLK    (HCLK),
      .POReset (POReset),
      .bus     (bus)
   );

   initial HCLK = 1'b0;
   always #5 HCLK = ~HCLK;

   task automatic adv(input int n);
      repeat (n) @(posedge HCLK);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic soft_pulse();
      bus.SoftRstReq = 1'b1;
      adv(1);
      bus.SoftRstReq = 1'b0;
   endtask

   initial begin
      tests          = 0;
      fails          = 0;
      POReset        = 1'b1;
      bus.SoftRstReq = 1'b0;
      bus.DomReady   = 3'b111;

      // Reset values before any clock edge
      #2;
      chk("rst_hresetn", 32'(bus.HRESETn), 32'h0);
      chk("rst_done", 32'(bus.SeqDone), 32'h0);
      chk("rst_terr", 32'(bus.TimeoutErr), 32'h0);
      adv(2);
      chk("rst_hold_hresetn", 32'(bus.HRESETn), 32'h0);

      // Nominal: POReset falls before E0
      POReset = 1'b0;
      adv(5);
      chk("nom_e4", 32'(bus.HRESETn), 32'h0);
      adv(1);
      chk("nom_e5", 32'(bus.HRESETn), 32'h1);
      adv(2);
      chk("nom_e7", 32'(bus.HRESETn), 32'h1);
      adv(1);
      chk("nom_e8", 32'(bus.HRESETn), 32'h3);
      adv(2);
      chk("nom_e10", 32'(bus.HRESETn), 32'h3);
      adv(1);
      chk("nom_e11", 32'(bus.HRESETn), 32'h7);
      chk("nom_e11_done", 32'(bus.SeqDone), 32'h0);
      adv(1);
      chk("nom_e12_done", 32'(bus.SeqDone), 32'h1);
      chk("nom_e12_terr", 32'(bus.TimeoutErr), 32'h0);
      bus.DomReady = 3'b000;
      adv(3);
      chk("done_hold_hresetn", 32'(bus.HRESETn), 32'h7);
      chk("done_hold_done", 32'(bus.SeqDone), 32'h1);
      bus.DomReady = 3'b111;

      // Soft reset pulse in DONE, then identical offsets from the soft edge
      soft_pulse();
      chk("soft_hresetn", 32'(bus.HRESETn), 32'h0);
      chk("soft_done", 32'(bus.SeqDone), 32'h0);
      adv(3);
      chk("soft_s3", 32'(bus.HRESETn), 32'h0);
      adv(1);
      chk("soft_s4", 32'(bus.HRESETn), 32'h1);
      adv(3);
      chk("soft_s7", 32'(bus.HRESETn), 32'h3);
      adv(3);
      chk("soft_s10", 32'(bus.HRESETn), 32'h7);
      adv(1);
      chk("soft_s11_done", 32'(bus.SeqDone), 32'h1);

      // Slow ack on domain 1: ready first sampled 5 edges after its release
      bus.DomReady = 3'b101;
      soft_pulse();
      adv(7);
      chk("slow_s7", 32'(bus.HRESETn), 32'h3);
      adv(4);
      bus.DomReady = 3'b111;
      adv(2);
      chk("slow_s13", 32'(bus.HRESETn), 32'h3);
      adv(1);
      chk("slow_s14", 32'(bus.HRESETn), 32'h7);
      adv(1);
      chk("slow_done", 32'(bus.SeqDone), 32'h1);
      chk("slow_terr", 32'(bus.TimeoutErr), 32'h0);

      // Timeout: domain 1 never acknowledges
      bus.DomReady = 3'b101;
      soft_pulse();
      adv(14);
      chk("to_s14_terr", 32'(bus.TimeoutErr), 32'h0);
      chk("to_s14_hresetn", 32'(bus.HRESETn), 32'h3);
      adv(1);
      chk("to_s15_terr", 32'(bus.TimeoutErr), 32'h1);
      adv(1);
      chk("to_s16", 32'(bus.HRESETn), 32'h3);
      adv(1);
      chk("to_s17", 32'(bus.HRESETn), 32'h7);
      chk("to_s17_done", 32'(bus.SeqDone), 32'h0);
      adv(1);
      chk("to_s18_done", 32'(bus.SeqDone), 32'h1);
      chk("to_sticky", 32'(bus.TimeoutErr), 32'h1);

      // Soft reset clears the error; ready on exactly the timeout edge is not a timeout
      soft_pulse();
      chk("soft_clr_terr", 32'(bus.TimeoutErr), 32'h0);
      adv(14);
      bus.DomReady = 3'b111;
      adv(1);
      chk("edge_ready_terr", 32'(bus.TimeoutErr), 32'h0);
      adv(2);
      chk("edge_ready_s17", 32'(bus.HRESETn), 32'h7);
      adv(1);
      chk("edge_ready_done", 32'(bus.SeqDone), 32'h1);
      chk("edge_ready_terr2", 32'(bus.TimeoutErr), 32'h0);

      // Soft request and ready on the same edge: soft reset wins
      bus.DomReady = 3'b101;
      soft_pulse();
      adv(8);
      chk("race_s8", 32'(bus.HRESETn), 32'h3);
      bus.DomReady   = 3'b111;
      bus.SoftRstReq = 1'b1;
      adv(1);
      bus.SoftRstReq = 1'b0;
      chk("race_hresetn", 32'(bus.HRESETn), 32'h0);
      chk("race_done", 32'(bus.SeqDone), 32'h0);
      adv(4);
      chk("race_restart_s4", 32'(bus.HRESETn), 32'h1);

      // Soft request held over three edges stretches the hold
      bus.SoftRstReq = 1'b1;
      adv(3);
      bus.SoftRstReq = 1'b0;
      adv(3);
      chk("held_t3", 32'(bus.HRESETn), 32'h0);
      adv(1);
      chk("held_t4", 32'(bus.HRESETn), 32'h1);

      // POReset asserted between edges while in GAP
      soft_pulse();
      adv(5);
      chk("async_pre", 32'(bus.HRESETn), 32'h1);
      #3;
      POReset = 1'b1;
      #1;
      chk("async_hresetn", 32'(bus.HRESETn), 32'h0);
      chk("async_done", 32'(bus.SeqDone), 32'h0);
      adv(2);
      POReset = 1'b0;
      adv(5);
      chk("async_e4", 32'(bus.HRESETn), 32'h0);
      adv(1);
      chk("async_e5", 32'(bus.HRESETn), 32'h1);
      adv(3);
      chk("async_e8", 32'(bus.HRESETn), 32'h3);
      adv(4);
      chk("async_e12_done", 32'(bus.SeqDone), 32'h1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
